// File: rtl/qspi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qspi_bus_arbiter
// Brief    : Shares one QPI bus (flash, RAM A, RAM B) between the instruction
//            fetch port and the data load/store port, sequencing each transfer.
// Revision : 1.0 - initial release
// ============================================================================
module qspi_bus_arbiter #(
    parameter int DUMMY_CYCLES = 6,
    parameter int CS_HIGH_CLKS = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        instr_req,
    input  logic [24:0] instr_addr,
    output logic [31:0] instr_rdata,
    output logic        instr_done,

    input  logic        data_req,
    input  logic        data_we,
    input  logic [1:0]  data_len,
    input  logic [24:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_done,

    output logic        busy,

    input  logic [3:0]  qspi_data_in,
    output logic [3:0]  qspi_data_out,
    output logic [3:0]  qspi_data_oe,
    output logic        qspi_clk_out,
    output logic        qspi_flash_select,
    output logic        qspi_ram_a_select,
    output logic        qspi_ram_b_select
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_CMD      = 3'd1;
    localparam logic [2:0] c_ST_ADDR     = 3'd2;
    localparam logic [2:0] c_ST_DUMMY    = 3'd3;
    localparam logic [2:0] c_ST_XFER     = 3'd4;
    localparam logic [2:0] c_ST_FINISH   = 3'd5;
    localparam logic [2:0] c_ST_DESEL    = 3'd6;
    localparam logic [2:0] c_ST_FLASH_WR = 3'd7;

    // One counter serves every segment, so it must hold the longest of them.
    localparam int c_CNT_MAX = (DUMMY_CYCLES > CS_HIGH_CLKS)
                             ? ((DUMMY_CYCLES > 8) ? DUMMY_CYCLES : 8)
                             : ((CS_HIGH_CLKS > 8) ? CS_HIGH_CLKS : 8);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CMD_LAST   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST  = c_CNT_W'(5);
    localparam logic [c_CNT_W-1:0] c_DUMMY_LAST = c_CNT_W'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_DESEL_LAST = c_CNT_W'(CS_HIGH_CLKS - 1);
    localparam logic [c_CNT_W-1:0] c_MODE_NIBS  = c_CNT_W'(2);
    localparam logic [c_CNT_W-1:0] c_XFER_LAST1 = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_XFER_LAST2 = c_CNT_W'(3);
    localparam logic [c_CNT_W-1:0] c_XFER_LAST4 = c_CNT_W'(7);

    localparam logic [7:0] c_CMD_READ  = 8'hEB;
    localparam logic [7:0] c_CMD_WRITE = 8'h38;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic               r_phase;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_port;        // 1 = data port owns the bus
    logic               r_we;
    logic [24:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [c_CNT_W-1:0] r_xfer_last;
    logic               r_last_grant;  // 0 = instr, 1 = data
    logic [31:0]        r_rx;
    logic [31:0]        w_rx_next;
    logic [31:0]        r_instr_rdata;
    logic [31:0]        r_data_rdata;

    logic               w_grant_any;
    logic               w_grant_data;
    logic               w_grant_flash_wr;
    logic               w_active;
    logic               w_spi_edge;
    logic               w_seg_last;
    logic               w_is_flash;
    logic               w_ram_b;
    logic [23:0]        w_dev_addr;
    logic [7:0]         w_cmd;
    logic [3:0]         w_addr_nib;
    logic [7:0]         w_wr_byte;
    logic [3:0]         w_wr_nib;
    logic               w_oe;

    // Round-robin on a tie: the port not served last wins.
    assign w_grant_any      = (r_state == c_ST_IDLE) && (instr_req || data_req);
    assign w_grant_data     = data_req && (!instr_req || !r_last_grant);
    assign w_grant_flash_wr = w_grant_data && data_we && !data_addr[24];

    assign w_active   = (r_state == c_ST_CMD) || (r_state == c_ST_ADDR) ||
                        (r_state == c_ST_DUMMY) || (r_state == c_ST_XFER);
    assign w_spi_edge = w_active && r_phase;

    always_comb begin
        w_seg_last = 1'b0;
        case (r_state)
            c_ST_CMD:   w_seg_last = (r_cnt == c_CMD_LAST);
            c_ST_ADDR:  w_seg_last = (r_cnt == c_ADDR_LAST);
            c_ST_DUMMY: w_seg_last = (r_cnt == c_DUMMY_LAST);
            c_ST_XFER:  w_seg_last = (r_cnt == r_xfer_last);
            c_ST_DESEL: w_seg_last = (r_cnt == c_DESEL_LAST);
            default:    w_seg_last = 1'b0;
        endcase
    end

    assign w_is_flash = !r_addr[24];
    assign w_ram_b    = r_addr[23];
    assign w_dev_addr = w_is_flash ? r_addr[23:0] : {1'b0, r_addr[22:0]};
    assign w_cmd      = r_we ? c_CMD_WRITE : c_CMD_READ;
    assign w_wr_byte  = r_wdata[{r_cnt[2:1], 3'b000} +: 8];
    assign w_wr_nib   = r_cnt[0] ? w_wr_byte[3:0] : w_wr_byte[7:4];

    always_comb begin
        w_addr_nib = 4'h0;
        case (r_cnt[2:0])
            3'd0:    w_addr_nib = w_dev_addr[23:20];
            3'd1:    w_addr_nib = w_dev_addr[19:16];
            3'd2:    w_addr_nib = w_dev_addr[15:12];
            3'd3:    w_addr_nib = w_dev_addr[11:8];
            3'd4:    w_addr_nib = w_dev_addr[7:4];
            3'd5:    w_addr_nib = w_dev_addr[3:0];
            default: w_addr_nib = 4'h0;
        endcase
    end

    // Byte k of the read lands at bits [8k+7:8k]; its high nibble arrives first.
    always_comb begin
        w_rx_next = r_rx;
        w_rx_next[{r_cnt[2:1], ~r_cnt[0], 2'b00} +: 4] = qspi_data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant_any) begin
                    w_state_next = w_grant_flash_wr ? c_ST_FLASH_WR : c_ST_CMD;
                end
            end
            c_ST_CMD: begin
                if (w_spi_edge && w_seg_last) w_state_next = c_ST_ADDR;
            end
            c_ST_ADDR: begin
                if (w_spi_edge && w_seg_last) begin
                    w_state_next = (r_we || (DUMMY_CYCLES == 0)) ? c_ST_XFER : c_ST_DUMMY;
                end
            end
            c_ST_DUMMY: begin
                if (w_spi_edge && w_seg_last) w_state_next = c_ST_XFER;
            end
            c_ST_XFER: begin
                if (w_spi_edge && w_seg_last) w_state_next = c_ST_FINISH;
            end
            c_ST_FINISH:   w_state_next = c_ST_DESEL;
            c_ST_DESEL: begin
                if (w_seg_last) w_state_next = c_ST_IDLE;
            end
            c_ST_FLASH_WR: w_state_next = c_ST_IDLE;
            default:       w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase       <= 1'b0;
            r_cnt         <= '0;
            r_port        <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_xfer_last   <= c_XFER_LAST4;
            r_last_grant  <= 1'b0;
            r_rx          <= '0;
            r_instr_rdata <= '0;
            r_data_rdata  <= '0;
        end else begin
            if (w_grant_any) begin
                r_port       <= w_grant_data;
                r_last_grant <= w_grant_data;
                r_addr       <= w_grant_data ? data_addr : instr_addr;
                r_we         <= w_grant_data && data_we;
                r_wdata      <= data_wdata;
                r_rx         <= '0;
                if (!w_grant_data) begin
                    r_xfer_last <= c_XFER_LAST4;
                end else begin
                    case (data_len)
                        2'd0:    r_xfer_last <= c_XFER_LAST1;
                        2'd1:    r_xfer_last <= c_XFER_LAST2;
                        default: r_xfer_last <= c_XFER_LAST4;
                    endcase
                end
            end

            if (w_state_next != r_state) begin
                r_phase <= 1'b0;
                r_cnt   <= '0;
            end else if (w_active) begin
                r_phase <= ~r_phase;
                if (r_phase) r_cnt <= r_cnt + 1'b1;
            end else if (r_state == c_ST_DESEL) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_spi_edge && (r_state == c_ST_XFER) && !r_we) begin
                r_rx <= w_rx_next;
                if (w_seg_last) begin
                    if (r_port) r_data_rdata  <= w_rx_next;
                    else        r_instr_rdata <= w_rx_next;
                end
            end
        end
    end

    always_comb begin
        qspi_flash_select = 1'b1;
        qspi_ram_a_select = 1'b1;
        qspi_ram_b_select = 1'b1;
        qspi_clk_out      = 1'b0;
        qspi_data_out     = 4'h0;
        w_oe              = 1'b0;
        instr_done        = 1'b0;
        data_done         = 1'b0;
        if (w_active) begin
            qspi_flash_select = !w_is_flash;
            qspi_ram_a_select = !(!w_is_flash && !w_ram_b);
            qspi_ram_b_select = !(!w_is_flash &&  w_ram_b);
            qspi_clk_out      = r_phase;
        end
        case (r_state)
            c_ST_CMD: begin
                w_oe          = 1'b1;
                qspi_data_out = r_cnt[0] ? w_cmd[3:0] : w_cmd[7:4];
            end
            c_ST_ADDR: begin
                w_oe          = 1'b1;
                qspi_data_out = w_addr_nib;
            end
            c_ST_DUMMY: begin
                // Flash mode byte 0xFF keeps it out of continuous-read mode.
                if (w_is_flash && (r_cnt < c_MODE_NIBS)) begin
                    w_oe          = 1'b1;
                    qspi_data_out = 4'hF;
                end
            end
            c_ST_XFER: begin
                if (r_we) begin
                    w_oe          = 1'b1;
                    qspi_data_out = w_wr_nib;
                end
            end
            c_ST_FINISH: begin
                instr_done = !r_port;
                data_done  = r_port;
            end
            c_ST_FLASH_WR: data_done = 1'b1;
            default: ;
        endcase
    end

    assign qspi_data_oe = {4{w_oe}};
    assign busy         = (r_state != c_ST_IDLE);
    assign instr_rdata  = r_instr_rdata;
    assign data_rdata   = r_data_rdata;

endmodule
`default_nettype wire

// File: tb/tb_qspi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_bus_arbiter
// Brief    : Directed bench with a QPI memory model and a completion scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_bus_arbiter;

    localparam int DUMMY = 6;
    localparam int CSH   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req = 1'b0;
    logic [24:0] instr_addr = '0;
    logic [31:0] instr_rdata;
    logic        instr_done;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [1:0]  data_len = '0;
    logic [24:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        busy;
    logic [3:0]  qspi_data_in = 4'h0;
    logic [3:0]  qspi_data_out;
    logic [3:0]  qspi_data_oe;
    logic        qspi_clk_out;
    logic        qspi_flash_select;
    logic        qspi_ram_a_select;
    logic        qspi_ram_b_select;

    always #5 clk = ~clk;

    qspi_bus_arbiter #(
        .DUMMY_CYCLES (DUMMY),
        .CS_HIGH_CLKS (CSH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_req         (instr_req),
        .instr_addr        (instr_addr),
        .instr_rdata       (instr_rdata),
        .instr_done        (instr_done),
        .data_req          (data_req),
        .data_we           (data_we),
        .data_len          (data_len),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_rdata        (data_rdata),
        .data_done         (data_done),
        .busy              (busy),
        .qspi_data_in      (qspi_data_in),
        .qspi_data_out     (qspi_data_out),
        .qspi_data_oe      (qspi_data_oe),
        .qspi_clk_out      (qspi_clk_out),
        .qspi_flash_select (qspi_flash_select),
        .qspi_ram_a_select (qspi_ram_a_select),
        .qspi_ram_b_select (qspi_ram_b_select)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          port;   // 1 = data
        bit          we;
        logic [31:0] rdata;
    } sb_t;
    sb_t sb_q[$];

    logic [7:0] trace[$];                 // {oe, nibble} per SPI clock
    logic [7:0] mem [logic [25:0]];       // key = {dev, device address}
    bit         seen_flash, seen_a, seen_b, seen_sclk;
    int         cs_gap = 0;
    bit         cs_was_low = 1'b0;
    int         nib_idx = 0;
    logic [7:0] mdl_cmd = '0;
    logic [23:0] mdl_addr = '0;
    logic [1:0] mdl_dev;
    logic [3:0] wr_hi = '0;

    logic [7:0] exp_fetch [10] = '{8'hFE, 8'hFB, 8'hF0, 8'hF0, 8'hF0, 8'hF1, 8'hF0, 8'hF0, 8'hFF, 8'hFF};
    logic [7:0] exp_write [10] = '{8'hF3, 8'hF8, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF4, 8'hFA, 8'hF5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [25:0] key);
        return mem.exists(key) ? mem[key] : 8'h00;
    endfunction

    task automatic push_exp(input bit port, input bit we, input logic [31:0] rdata);
        sb_t e;
        e.port  = port;
        e.we    = we;
        e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    // Memory model and bus monitor: data is presented in phase0, captured in phase1.
    always @(negedge clk) begin
        logic [2:0] cs;
        int         k;
        logic [7:0] b;
        cs = {qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select};
        if (!cs[2]) seen_flash = 1'b1;
        if (!cs[1]) seen_a = 1'b1;
        if (!cs[0]) seen_b = 1'b1;
        if (qspi_clk_out) seen_sclk = 1'b1;
        if (cs == 3'b111) begin
            nib_idx = 0;
            if (cs_was_low) cs_gap++;
        end else begin
            chk("cs_onehot", $countones(~cs), 1);
            if (cs_was_low && cs_gap > 0) chk("cs_high_gap", (cs_gap >= CSH), 1);
            cs_gap     = 0;
            cs_was_low = 1'b1;
            mdl_dev    = !cs[2] ? 2'd0 : (!cs[1] ? 2'd1 : 2'd2);
            if (!qspi_clk_out) begin
                if (nib_idx >= 8 + DUMMY && mdl_cmd == 8'hEB) begin
                    k = nib_idx - 8 - DUMMY;
                    b = mem_rd({mdl_dev, mdl_addr + 24'(k / 2)});
                    qspi_data_in = k[0] ? b[3:0] : b[7:4];
                end
            end else begin
                trace.push_back({qspi_data_oe, qspi_data_out});
                if (nib_idx < 2) begin
                    mdl_cmd = {mdl_cmd[3:0], qspi_data_out};
                end else if (nib_idx < 8) begin
                    mdl_addr = {mdl_addr[19:0], qspi_data_out};
                end else if (mdl_cmd == 8'h38) begin
                    k = nib_idx - 8;
                    if (!k[0]) wr_hi = qspi_data_out;
                    else mem[{mdl_dev, mdl_addr + 24'(k / 2)}] = {wr_hi, qspi_data_out};
                end
                nib_idx++;
            end
        end
    end

    // Scoreboard: every completion pops the oldest expectation.
    always @(negedge clk) begin
        sb_t e;
        if (instr_done || data_done) begin
            chk("done_exclusive", instr_done && data_done, 0);
            chk("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("done_port", data_done, e.port);
                if (!e.we) chk("rdata", e.port ? data_rdata : instr_rdata, e.rdata);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("return_idle", busy, 0);
    endtask

    task automatic do_txn(input bit port, input bit we, input logic [1:0] len,
                          input logic [24:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input int exp_lat);
        int cyc = 1;
        bit seen = 1'b0;
        push_exp(port, we, exp);
        trace.delete();
        seen_flash = 1'b0; seen_a = 1'b0; seen_b = 1'b0; seen_sclk = 1'b0;
        if (port) begin
            data_we = we; data_len = len; data_addr = addr; data_wdata = wdata; data_req = 1'b1;
        end else begin
            instr_addr = addr; instr_req = 1'b1;
        end
        while (!seen && cyc < 200) begin
            @(negedge clk);
            if (port ? data_done : instr_done) seen = 1'b1;
            else cyc++;
        end
        instr_req = 1'b0;
        data_req  = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", cyc, exp_lat);
        wait_idle();
    endtask

    initial begin
        int n;
        int cyc;
        mem[{2'd0, 24'h000100}] = 8'h78;
        mem[{2'd0, 24'h000101}] = 8'h56;
        mem[{2'd0, 24'h000102}] = 8'h34;
        mem[{2'd0, 24'h000103}] = 8'h12;
        mem[{2'd1, 24'h000010}] = 8'hCD;
        mem[{2'd1, 24'h000011}] = 8'hAB;

        repeat (3) @(negedge clk);
        chk("rst_cs", {qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select}, 3'b111);
        chk("rst_sclk", qspi_clk_out, 0);
        chk("rst_oe", qspi_data_oe, 0);
        chk("rst_dout", qspi_data_out, 0);
        chk("rst_dones", {instr_done, data_done}, 0);
        chk("rst_instr_rdata", instr_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch from flash
        do_txn(1'b0, 1'b0, 2'd0, 25'h0000100, 32'h0, 32'h12345678, 45);
        chk("fetch_len", trace.size(), 22);
        for (int i = 0; i < 10 && i < trace.size(); i++) chk("fetch_nib", trace[i], exp_fetch[i]);
        for (int i = 10; i < trace.size(); i++) chk("fetch_rd_oe", trace[i][7:4], 0);
        chk("fetch_flash_sel", seen_flash, 1);
        chk("fetch_ram_idle", seen_a || seen_b, 0);

        // 1-byte write to RAM B
        do_txn(1'b1, 1'b1, 2'd0, 25'h1800004, 32'h000000A5, 32'h0, 21);
        chk("wr_len", trace.size(), 10);
        for (int i = 0; i < 10 && i < trace.size(); i++) chk("wr_nib", trace[i], exp_write[i]);
        chk("wr_ram_b_sel", seen_b, 1);
        chk("wr_others_idle", seen_a || seen_flash, 0);

        // 2-byte read from RAM A, read back of RAM B, 4-byte data read from flash
        do_txn(1'b1, 1'b0, 2'd1, 25'h1000010, 32'h0, 32'h0000ABCD, 37);
        chk("rd_a_sel", seen_a, 1);
        do_txn(1'b1, 1'b0, 2'd0, 25'h1800004, 32'h0, 32'h000000A5, 33);
        do_txn(1'b1, 1'b0, 2'd2, 25'h0000100, 32'h0, 32'h12345678, 45);
        chk("instr_rdata_hold", instr_rdata, 32'h12345678);

        // Flash write: no bus activity
        do_txn(1'b1, 1'b1, 2'd0, 25'h0000020, 32'h11223344, 32'h0, 1);
        chk("fwr_no_cs", seen_flash || seen_a || seen_b, 0);
        chk("fwr_no_sclk", seen_sclk, 0);
        chk("fwr_no_nibbles", trace.size(), 0);
        chk("data_rdata_hold", data_rdata, 32'h12345678);

        // Both requesters held from reset: data, instr, data, instr
        rst_n = 1'b0;
        instr_addr = 25'h0000100;
        data_we = 1'b0; data_len = 2'd1; data_addr = 25'h1000010;
        instr_req = 1'b1; data_req = 1'b1;
        push_exp(1'b1, 1'b0, 32'h0000ABCD);
        push_exp(1'b0, 1'b0, 32'h12345678);
        push_exp(1'b1, 1'b0, 32'h0000ABCD);
        push_exp(1'b0, 1'b0, 32'h12345678);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (instr_done || data_done) n++;
        end
        instr_req = 1'b0;
        data_req  = 1'b0;
        chk("arb_done_count", n, 4);
        wait_idle();

        // Reset during the address phase
        instr_addr = 25'h0000100;
        instr_req  = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_cs_low", qspi_flash_select, 0);
        rst_n     = 1'b0;
        instr_req = 1'b0;
        @(negedge clk);
        chk("abort_cs", {qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select}, 3'b111);
        chk("abort_oe", qspi_data_oe, 0);
        chk("abort_dones", {instr_done, data_done}, 0);
        chk("abort_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_txn(1'b0, 1'b0, 2'd0, 25'h0000100, 32'h0, 32'h12345678, 45);

        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
